// File: rtl/bit_free_return.sv
// Free-slot bitmap owner for the 4-way bit allocator.
// Removes granted allocations, returns retired slots one cycle late,
// fills the bitmap chunk by chunk after reset/flush and flags protocol errors.
module bit_free_return #(
  parameter int WIDTH      = 32,
  parameter int CNTW       = 6,
  parameter int INIT_CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             flush,
  input  logic [WIDTH-1:0] alloc0,
  input  logic [WIDTH-1:0] alloc1,
  input  logic [WIDTH-1:0] alloc2,
  input  logic [WIDTH-1:0] alloc3,
  input  logic [WIDTH-1:0] free0,
  input  logic [WIDTH-1:0] free1,
  input  logic [WIDTH-1:0] free2,
  input  logic [WIDTH-1:0] free3,
  output logic [WIDTH-1:0] bits,
  output logic [CNTW-1:0]  freeCnt,
  output logic             ready,
  output logic             errDoubleFree,
  output logic             errBadAlloc
);

  localparam int NCHUNK = WIDTH / INIT_CHUNK;
  localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_reg, state_next;
  logic [PTRW-1:0]  ptr_reg, ptr_next;
  logic [WIDTH-1:0] bits_reg, bits_next;
  logic [WIDTH-1:0] free_reg, free_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;
  logic             ready_reg, ready_next;
  logic             dbl_reg, dbl_next;
  logic             bad_reg, bad_next;

  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] alloc_all, free_all;
  logic [WIDTH-1:0] alloc_ovl, free_ovl;
  logic             last_chunk;

  // One chunk-wide field of ones selected by the init pointer.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign chunk_mask[gi*INIT_CHUNK +: INIT_CHUNK] = {INIT_CHUNK{ptr_reg == PTRW'(gi)}};
  end

  assign last_chunk = (ptr_reg == PTRW'(NCHUNK - 1));

  assign alloc_all = alloc0 | alloc1 | alloc2 | alloc3;
  assign free_all  = free0 | free1 | free2 | free3;
  // Any bit claimed by two ports at once.
  assign alloc_ovl = (alloc0 & (alloc1 | alloc2 | alloc3)) | (alloc1 & (alloc2 | alloc3)) | (alloc2 & alloc3);
  assign free_ovl  = (free0 & (free1 | free2 | free3)) | (free1 & (free2 | free3)) | (free2 & free3);

  function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction

  // Next-state: flush beats init fill, which beats normal alloc/free traffic.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    bits_next  = bits_reg;
    free_next  = free_reg;
    ready_next = ready_reg;
    dbl_next   = 1'b0;
    bad_next   = 1'b0;
    if (flush) begin
      state_next = ST_INIT;
      ptr_next   = '0;
      bits_next  = '0;
      free_next  = '0;
      ready_next = 1'b0;
    end else if (state_reg == ST_INIT) begin
      bits_next = bits_reg | chunk_mask;
      ptr_next  = ptr_reg + PTRW'(1);
      if (last_chunk) begin
        state_next = ST_RUN;
        ready_next = 1'b1;
        ptr_next   = '0;
      end
    end else if (clkEn) begin
      // Staged frees override a same-cycle allocation of the same slot.
      bits_next = (bits_reg & ~alloc_all) | free_reg;
      free_next = free_all;
      dbl_next  = (|(free_all & bits_reg)) | (|(free_all & free_reg)) | (|free_ovl);
      bad_next  = (|(alloc_all & ~bits_reg & ~free_reg)) | (|alloc_ovl);
    end
    cnt_next = popcount(bits_next);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
      bits_reg  <= '0;
      free_reg  <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      dbl_reg   <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      bits_reg  <= bits_next;
      free_reg  <= free_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      dbl_reg   <= dbl_next;
      bad_reg   <= bad_next;
    end
  end

  assign bits          = bits_reg;
  assign freeCnt       = cnt_reg;
  assign ready         = ready_reg;
  assign errDoubleFree = dbl_reg;
  assign errBadAlloc   = bad_reg;

endmodule

// File: tb/tb_bit_free_return.sv
// Self-checking bench for bit_free_return: directed spec scenarios, then
// randomized traffic compared against a per-slot reference model.
module tb_bit_free_return;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          flush;
  logic [W-1:0]  alloc_v [4];
  logic [W-1:0]  free_v  [4];
  logic [W-1:0]  bits;
  logic [5:0]    free_cnt;
  logic          ready;
  logic          err_double_free;
  logic          err_bad_alloc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-slot state
  bit m_free [W];
  bit m_pend [W];
  int m_filled;
  bit m_run;
  bit m_dbl, m_bad;

  always #5 clk = ~clk;

  bit_free_return #(.WIDTH(32), .CNTW(6), .INIT_CHUNK(8)) dut (
    .clk(clk), .rst(rst), .clkEn(clk_en), .flush(flush),
    .alloc0(alloc_v[0]), .alloc1(alloc_v[1]), .alloc2(alloc_v[2]), .alloc3(alloc_v[3]),
    .free0(free_v[0]), .free1(free_v[1]), .free2(free_v[2]), .free3(free_v[3]),
    .bits(bits), .freeCnt(free_cnt), .ready(ready),
    .errDoubleFree(err_double_free), .errBadAlloc(err_bad_alloc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit nf [W];
    bit np [W];
    int na, nfr;
    if (!rst) begin
      m_filled = 0; m_run = 0; m_dbl = 0; m_bad = 0;
      for (int s = 0; s < W; s++) begin m_free[s] = 0; m_pend[s] = 0; end
    end else if (flush) begin
      m_filled = 0; m_run = 0; m_dbl = 0; m_bad = 0;
      for (int s = 0; s < W; s++) begin m_free[s] = 0; m_pend[s] = 0; end
    end else if (!m_run) begin
      m_filled++;
      for (int s = 0; s < W; s++) if (s < m_filled * 8) m_free[s] = 1;
      if (m_filled * 8 >= W) m_run = 1;
      m_dbl = 0; m_bad = 0;
    end else if (clk_en) begin
      m_dbl = 0; m_bad = 0;
      for (int s = 0; s < W; s++) begin
        na = 0; nfr = 0;
        for (int p = 0; p < 4; p++) begin
          na  += int'(alloc_v[p][s]);
          nfr += int'(free_v[p][s]);
        end
        if (na > 1 || (na > 0 && !m_free[s] && !m_pend[s])) m_bad = 1;
        if (nfr > 1 || (nfr > 0 && (m_free[s] || m_pend[s]))) m_dbl = 1;
        nf[s] = m_pend[s] ? 1'b1 : ((na > 0) ? 1'b0 : m_free[s]);
        np[s] = (nfr > 0);
      end
      for (int s = 0; s < W; s++) begin m_free[s] = nf[s]; m_pend[s] = np[s]; end
    end else begin
      m_dbl = 0; m_bad = 0;
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] mb;
    int cnt;
    cnt = 0;
    for (int s = 0; s < W; s++) begin mb[s] = m_free[s]; cnt += int'(m_free[s]); end
    check("bits", 64'(bits), 64'(mb));
    check("freeCnt", 64'(free_cnt), 64'(cnt));
    check("ready", 64'(ready), 64'(m_run));
    check("errDoubleFree", 64'(err_double_free), 64'(m_dbl));
    check("errBadAlloc", 64'(err_bad_alloc), 64'(m_bad));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) begin alloc_v[p] = '0; free_v[p] = '0; end
    flush = 1'b0;
  endtask

  function automatic logic [W-1:0] onehot(input int s);
    logic [W-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [W-1:0] init_tab [4];
    init_tab[0] = 32'h0000_00FF; init_tab[1] = 32'h0000_FFFF;
    init_tab[2] = 32'h00FF_FFFF; init_tab[3] = 32'hFFFF_FFFF;

    rst = 1'b0; clk_en = 1'b1;
    idle_inputs();
    #1;
    tick(); tick();
    check("reset_bits", 64'(bits), 64'h0);
    check("reset_ready", 64'(ready), 64'h0);
    $display("reset: bits=%h ready=%0d", bits, ready);

    // 1. init fill, clkEn low to show it does not stall init
    rst = 1'b1; clk_en = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("init_bits", 64'(bits), 64'(init_tab[e]));
      $display("init edge %0d: bits=%h ready=%0d cnt=%0d", e + 1, bits, ready, free_cnt);
    end
    check("init_ready", 64'(ready), 64'h1);
    check("init_cnt", 64'(free_cnt), 64'd32);
    clk_en = 1'b1;

    // 2. alloc at both ends of the bitmap
    alloc_v[0] = 32'h1; alloc_v[3] = 32'h8000_0000;
    tick(); idle_inputs();
    check("alloc_bits", 64'(bits), 64'h7FFF_FFFE);
    check("alloc_cnt", 64'(free_cnt), 64'd30);
    check("alloc_noerr", 64'({err_double_free, err_bad_alloc}), 64'h0);
    $display("alloc: bits=%h cnt=%0d", bits, free_cnt);

    // 3. free latency of two edges
    free_v[1] = 32'h1;
    tick(); idle_inputs();
    check("free_n1_bits", 64'(bits), 64'h7FFF_FFFE);
    tick();
    check("free_n2_bits", 64'(bits), 64'h7FFF_FFFF);
    check("free_n2_cnt", 64'(free_cnt), 64'd31);
    $display("free: bits=%h cnt=%0d", bits, free_cnt);

    // 4. double free of an already-free slot
    free_v[0] = 32'h4;
    tick(); idle_inputs();
    check("dbl_pulse", 64'(err_double_free), 64'h1);
    tick();
    check("dbl_clear", 64'(err_double_free), 64'h0);
    check("dbl_bits", 64'(bits), 64'h7FFF_FFFF);
    check("dbl_cnt", 64'(free_cnt), 64'd31);
    $display("double free: bits=%h cnt=%0d", bits, free_cnt);

    // 5. bad alloc plus overlapping free ports in one cycle
    alloc_v[0] = 32'h2;
    tick(); idle_inputs();
    alloc_v[1] = 32'h2; free_v[2] = 32'h8; free_v[3] = 32'h8;
    tick(); idle_inputs();
    check("bad_pulse", 64'(err_bad_alloc), 64'h1);
    check("ovl_pulse", 64'(err_double_free), 64'h1);
    tick();
    check("bad_clear", 64'(err_bad_alloc), 64'h0);
    $display("bad alloc: bits=%h cnt=%0d", bits, free_cnt);

    // 6. pending free discarded by flush, then refill; then clkEn hold
    free_v[0] = 32'h2;
    tick(); idle_inputs();
    flush = 1'b1;
    tick(); idle_inputs();
    check("flush_ready", 64'(ready), 64'h0);
    check("flush_bits", 64'(bits), 64'h0);
    for (int e = 0; e < 4; e++) tick();
    check("reinit_bits", 64'(bits), 64'hFFFF_FFFF);
    check("reinit_ready", 64'(ready), 64'h1);
    clk_en = 1'b0; alloc_v[0] = 32'h10;
    tick(); tick(); idle_inputs();
    check("hold_bits", 64'(bits), 64'hFFFF_FFFF);
    clk_en = 1'b1;
    $display("flush/hold: bits=%h cnt=%0d", bits, free_cnt);

    // Randomized traffic checked every cycle against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 99) < 30) begin
          int s;
          s = int'($urandom_range(0, W - 1));
          if ($urandom_range(0, 99) < 85)
            for (int k = 0; k < W; k++)
              if (m_free[(s + k) % W] && !(alloc_v[0][(s + k) % W] | alloc_v[1][(s + k) % W] |
                                           alloc_v[2][(s + k) % W] | alloc_v[3][(s + k) % W])) begin
                s = (s + k) % W; break;
              end
          alloc_v[p] = onehot(s);
        end
        if ($urandom_range(0, 99) < 25) begin
          int s;
          s = int'($urandom_range(0, W - 1));
          if ($urandom_range(0, 99) < 85)
            for (int k = 0; k < W; k++)
              if (!m_free[(s + k) % W] && !m_pend[(s + k) % W]) begin s = (s + k) % W; break; end
          free_v[p] = onehot(s);
        end
      end
      clk_en = ($urandom_range(0, 99) < 90);
      flush  = ($urandom_range(0, 199) == 0);
      rst    = !(cyc == 1500);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    $display("random phase: %0d cycles", 3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
